// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store per request handshake, completion after LATENCY cycles.
// Optional DMEM_CONFLICT_ERR_EN: read+write requests complete with rsp_err instead of acting as stores.
module dmem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_is_write,
    output logic        busy
`ifdef DMEM_CONFLICT_ERR_EN
    ,
    output logic        rsp_err
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic [7:0]  addr_reg;
    logic [31:0] wdata_reg;
    logic        op_write_reg;
    logic        op_err_reg;

    logic        accept;
    logic        commit;
    logic        req_err;
    logic        req_write_eff;
    logic [7:0]  cmt_addr;
    logic [31:0] cmt_wdata;
    logic        cmt_write;
    logic        cmt_err;
    logic [AW-1:0] mem_idx;

    logic [31:0] mem [DEPTH];
    logic [31:0] ram_q;
    logic        rsp_load_reg;
    logic        rsp_is_write_reg;

`ifdef DMEM_CONFLICT_ERR_EN
    assign req_err = req_read & req_write;
`else
    assign req_err = 1'b0;
`endif
    assign req_write_eff = req_write & ~req_err;

    assign accept = (state_reg == IDLE) && req_valid && (req_read || req_write);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY=1 the commit edge is the acceptance edge, so take the live request fields.
    always_comb begin
        if (state_reg == IDLE) begin
            cmt_addr  = req_addr;
            cmt_wdata = req_wdata;
            cmt_write = req_write_eff;
            cmt_err   = req_err;
        end else begin
            cmt_addr  = addr_reg;
            cmt_wdata = wdata_reg;
            cmt_write = op_write_reg;
            cmt_err   = op_err_reg;
        end
    end

    // Reset gates the commit so an aborted store never reaches the array.
    assign commit  = (state_next == RESP) && (state_reg != RESP) && !reset;
    assign mem_idx = AW'(32'(cmt_addr) % 32'(DEPTH));

    always_ff @(posedge clock) begin
        if (commit) begin
            if (cmt_write) begin
                mem[mem_idx] <= cmt_wdata;
            end
            ram_q <= mem[mem_idx];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            cnt_reg          <= 4'd0;
            addr_reg         <= 8'd0;
            wdata_reg        <= 32'd0;
            op_write_reg     <= 1'b0;
            op_err_reg       <= 1'b0;
            rsp_load_reg     <= 1'b0;
            rsp_is_write_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg     <= req_addr;
                wdata_reg    <= req_wdata;
                op_write_reg <= req_write_eff;
                op_err_reg   <= req_err;
            end
            if (commit) begin
                rsp_load_reg     <= !cmt_write && !cmt_err;
                rsp_is_write_reg <= cmt_write;
            end
        end
    end

`ifdef DMEM_CONFLICT_ERR_EN
    logic rsp_err_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp_err_reg <= 1'b0;
        end else if (commit) begin
            rsp_err_reg <= cmt_err;
        end
    end

    assign rsp_err = rsp_err_reg;
`endif

    assign req_ready    = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign rsp_valid    = (state_reg == RESP);
    assign rsp_is_write = rsp_is_write_reg;
    // Stores, conflicts and reset present zero; ram_q is only exposed after a load commit.
    assign rsp_rdata    = rsp_load_reg ? ram_q : 32'd0;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory side of the load/store interface driven by the pipeline's memory stage.
- Accepts one read or write request per transaction over a valid/ready handshake.
- Services it after a programmable access latency and returns a completion (read data or write ack) over a second valid/ready handshake.
- Replaces the zero-latency array so the memory stage and hazard logic can be exercised against realistic multi-cycle memory.

Parameters:
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.
- DEPTH, 256, number of 32-bit words; address width is fixed at 8 bits (word index).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_read  input  1  load request (MemRead)
- req_write  input  1  store request (MemWrite)
- req_addr  input  8  word address (alu_result[7:0])
- req_wdata  input  32  store data (valB)
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester consumes response
- rsp_rdata  output  32  load data; 0 for stores
- rsp_is_write  output  1  response completes a store
- busy  output  1  transaction in flight (stall source for the pipeline)

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset forces IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_is_write=0, busy=0, latency counter=0. Memory contents are not cleared.
- IDLE:
  - req_ready=1, busy=0.
  - Request is accepted on a cycle with req_valid=1, req_ready=1 and (req_read|req_write)=1.
  - On acceptance, addr, wdata and operation type are latched.
  - If LATENCY=1, go to RESP; otherwise go to WAIT with counter=LATENCY-2.
- Request with req_valid=1 and req_read=req_write=0: not accepted, no state change, req_ready stays 1.
- WAIT:
  - req_ready=0, busy=1.
  - Counter decrements each cycle; when the counter is 0, go to RESP.
- Transition into RESP (commit edge):
  - Store: mem[addr] <= wdata; rsp_rdata <= 0; rsp_is_write <= 1.
  - Load: rsp_rdata <= mem[addr] (contents as of that edge); rsp_is_write <= 0.
- Latency: rsp_valid rises exactly LATENCY clock edges after the acceptance edge.
- RESP:
  - rsp_valid=1, busy=1, req_ready=0.
  - rsp_rdata and rsp_is_write are held stable until the handshake (rsp_valid & rsp_ready).
  - On the handshake, go to IDLE and drop rsp_valid the next cycle. rsp_rdata retains its last value and is don't-care.
- No back-to-back overlap: the next request is acceptable only in IDLE, so minimum issue interval is LATENCY+1 cycles with rsp_ready held high.
- req_read and req_write both 1: treated as a store (write wins); see optional feature.
- Address: full 8 bits used; DEPTH=256 gives no aliasing. For DEPTH<256, index is addr mod DEPTH.
- Reset mid-operation: the transaction is aborted immediately and outputs return to reset values.
  - A store not yet at its commit edge is discarded; memory is unchanged.
  - A load response that has not been handshaken is lost.
- req_* inputs are ignored outside IDLE. Changes to them after acceptance have no effect.
- rsp_ready asserted while rsp_valid=0 has no effect.

Optional Feature:
- Macro DMEM_CONFLICT_ERR_EN.
- Defined:
  - Adds output rsp_err (1 bit, reset 0), valid with rsp_valid.
  - A request with both req_read and req_write set is accepted, performs no memory access, and completes after the normal latency with rsp_err=1, rsp_rdata=0, rsp_is_write=0.
  - Normal requests return rsp_err=0.
- Undefined:
  - The port is absent; write-wins behaviour applies.

Test Plan:
- Reset then write: store addr=0x10, data=0xDEADBEEF, LATENCY=2, rsp_ready=1 -> rsp_valid high 2 edges after acceptance, rsp_is_write=1, rsp_rdata=0, busy=1 during WAIT/RESP.
- Read-after-write: load addr=0x10 -> rsp_rdata=0xDEADBEEF, rsp_is_write=0. Load addr=0x11 (never written, preloaded 0x00000000) -> 0.
- Backpressure: load addr=0x10 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata=0xDEADBEEF held stable, req_ready=0. A second req_valid during the stall is not accepted.
- No-op and boundary: req_valid=1 with read=write=0 -> no acceptance, state IDLE. Store 0x12345678 to addr=0xFF then load 0xFF -> 0x12345678, addr 0x00 unaffected. LATENCY=1 build -> response on the next edge.
- Reset mid-store: store addr=0x20, data=0xA5A5A5A5, assert reset during WAIT -> all outputs 0, req_ready=1. Subsequent load of 0x20 returns the prior value.
- Conflict: req_read=req_write=1, addr=0x30, data=0x1 -> with DMEM_CONFLICT_ERR_EN: rsp_err=1 and mem[0x30] unchanged; without it: store performed, later load of 0x30 returns 0x1.
